pipeline_sequencer: RTL and testbench

Central pipeline controller for the 16-bit CPU. It arbitrates three hazard sources (data-memory wait, load-use dependency, taken branch) and drives the PC, IF/ID and ID/EX enables, flushes and bubbles. It sits between the ID-stage branch resolution, the EX-stage load tracking and the data-memory handshake, and it owns the multi-cycle flush and stall sequencing.

---
 rtl/pipeline_sequencer_pkg.sv | 30 +++
 rtl/pipeline_sequencer_stat_counter.sv | 21 ++
 rtl/pipeline_sequencer.sv | 155 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: opcode macros, FSM state
// encoding and the taken-branch decode helper.
// Optional feature macro used by this slice: HAZARD_STATS_EN.

`ifndef PIPELINE_SEQUENCER_OPCODES
`define PIPELINE_SEQUENCER_OPCODES
`define BEQ 4'd8
`define B   4'd9
`define BL  4'd10
`define BR  4'd11
`endif

package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } seq_state_e;

    localparam int CNT_W = 3;

    // Unconditional branches always redirect; beq only when its compare hit
    function automatic logic taken_branch(input logic [3:0] opcode,
                                          input logic       beq_taken);
        return (opcode == `B) || (opcode == `BL) || (opcode == `BR) ||
               ((opcode == `BEQ) && beq_taken);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_stat_counter.sv
// 16-bit saturating event counter used for hazard statistics.
// Only built when HAZARD_STATS_EN is defined.

`ifdef HAZARD_STATS_EN
module hazard_stat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    // Count events, sticking at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_count <= 16'd0;
        else if (i_inc && (o_count != 16'hFFFF))
            o_count <= o_count + 16'd1;
    end

endmodule
`endif

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: arbitrates memory wait, load-use and taken
// branch hazards and sequences multi-cycle flushes and memory stalls.
// Optional feature: HAZARD_STATS_EN adds stall_count / flush_count.

module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ID_opcode,
    input  logic        ID_branch_taken,
    input  logic [3:0]  ID_rs,
    input  logic [3:0]  ID_rt,
    input  logic        EX_mem_read,
    input  logic [3:0]  EX_rt_rd,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_sync_nop,
    output logic        ID_EX_bubble,
    output logic        EX_MEM_hold
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    seq_state_e        r_state;
    seq_state_e        r_saved;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_init;

    seq_state_e        w_state_nxt;
    seq_state_e        w_saved_nxt;
    seq_state_e        w_eff;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_init;
    logic              w_mem_wait;
    logic              w_load_use;
    logic              w_taken;
    logic              w_stall_evt;
    logic              w_flush_evt;

    assign w_mem_wait = MEM_req && !MEM_ready;
    assign w_load_use = EX_mem_read && ((EX_rt_rd == ID_rs) || (EX_rt_rd == ID_rt));
    assign w_taken    = taken_branch(ID_opcode, ID_branch_taken);

    // Outputs stay in their safe reset pattern for the cycle after release too
    assign w_init = rst || r_init;

    // The cycle MEM_ready arrives behaves as the interrupted state would,
    // so a flush cycle released from a stall still counts toward the flush
    assign w_eff = (r_state == MEM_WAIT) ? r_saved : r_state;

    // State, saved state, flush counter and post-reset marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_cnt   <= '0;
            r_init  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_cnt   <= w_cnt_nxt;
            r_init  <= 1'b0;
        end
    end

    // Hazard arbitration: next state and Mealy control outputs
    always_comb begin
        PC_write       = 1'b0;
        IF_ID_write    = 1'b0;
        IF_ID_sync_nop = 1'b0;
        ID_EX_bubble   = 1'b0;
        EX_MEM_hold    = 1'b0;
        w_state_nxt    = r_state;
        w_saved_nxt    = r_saved;
        w_cnt_nxt      = r_cnt;
        w_stall_evt    = 1'b0;
        w_flush_evt    = 1'b0;

        if (w_init) begin
            IF_ID_sync_nop = 1'b1;
            ID_EX_bubble   = 1'b1;
            w_state_nxt    = RUN;
            w_saved_nxt    = RUN;
            w_cnt_nxt      = '0;
        end else if (w_mem_wait) begin
            // Freeze everything; a nop being flushed into IF/ID stays asserted
            EX_MEM_hold    = 1'b1;
            IF_ID_sync_nop = (w_eff == FLUSH);
            w_state_nxt    = MEM_WAIT;
            w_saved_nxt    = w_eff;
            w_stall_evt    = 1'b1;
        end else begin
            w_state_nxt = w_eff;
            w_saved_nxt = w_eff;
            case (w_eff)
                FLUSH: begin
                    // ID holds a nop here, so branch and load-use are ignored
                    PC_write       = 1'b1;
                    IF_ID_write    = 1'b1;
                    IF_ID_sync_nop = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (w_load_use) begin
                        // Branch in ID is re-evaluated once the load resolves
                        ID_EX_bubble = 1'b1;
                        w_stall_evt  = 1'b1;
                    end else if (w_taken) begin
                        PC_write       = 1'b1;
                        IF_ID_write    = 1'b1;
                        IF_ID_sync_nop = 1'b1;
                        w_flush_evt    = 1'b1;
                        w_cnt_nxt      = FLUSH_LOAD;
                        w_state_nxt    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_stat_counter u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall_evt),
        .o_count (stall_count)
    );

    hazard_stat_counter u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush_evt),
        .o_count (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer (FLUSH_CYCLES = 2).
// Output vector order: {PC_write, IF_ID_write, IF_ID_sync_nop, ID_EX_bubble, EX_MEM_hold}.

`timescale 1ns/1ps

module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ID_opcode;
    logic        ID_branch_taken;
    logic [3:0]  ID_rs;
    logic [3:0]  ID_rt;
    logic        EX_mem_read;
    logic [3:0]  EX_rt_rd;
    logic        MEM_req;
    logic        MEM_ready;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_ID_sync_nop;
    logic        ID_EX_bubble;
    logic        EX_MEM_hold;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    pipeline_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_opcode       (ID_opcode),
        .ID_branch_taken (ID_branch_taken),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .EX_mem_read     (EX_mem_read),
        .EX_rt_rd        (EX_rt_rd),
        .MEM_req         (MEM_req),
        .MEM_ready       (MEM_ready),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_sync_nop  (IF_ID_sync_nop),
        .ID_EX_bubble    (ID_EX_bubble),
        .EX_MEM_hold     (EX_MEM_hold)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive after the edge, push expectation, compare mid-cycle
    task automatic step(input string tag, input logic r, input logic [3:0] op,
                        input logic tk, input logic [3:0] rs, input logic [3:0] rt,
                        input logic exmr, input logic [3:0] exrd,
                        input logic mreq, input logic mrdy, input logic [4:0] exp);
        logic [4:0] e;
        string      t;
        @(posedge clk);
        #1;
        rst = r; ID_opcode = op; ID_branch_taken = tk; ID_rs = rs; ID_rt = rt;
        EX_mem_read = exmr; EX_rt_rd = exrd; MEM_req = mreq; MEM_ready = mrdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 32'({PC_write, IF_ID_write, IF_ID_sync_nop, ID_EX_bubble, EX_MEM_hold}), 32'(e));
    endtask

    initial begin
        rst = 1'b1; ID_opcode = 4'd0; ID_branch_taken = 1'b0; ID_rs = 4'd1; ID_rt = 4'd2;
        EX_mem_read = 1'b0; EX_rt_rd = 4'd0; MEM_req = 1'b0; MEM_ready = 1'b0;

        // reset held three cycles, then one forced cycle after release
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b00110);
        step("rst_rel1",   0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b00110);
        step("run",        0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // unconditional branch: two flush cycles then normal advance
        step("b_f1",       0, `B,   0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("b_f2",       0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("b_done",     0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // load-use beats a simultaneous taken beq; flush begins next cycle
        step("lu_beq",     0, `BEQ, 1, 4'd3, 4'd2, 1, 4'd3, 0, 0, 5'b00010);
        step("lu_br_f1",   0, `BEQ, 1, 4'd3, 4'd2, 0, 4'd3, 0, 0, 5'b11100);
        step("lu_br_f2",   0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("lu_br_done", 0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // beq not taken advances normally
        step("beq_nt",     0, `BEQ, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // memory wait during the second flush cycle: 4 held cycles
        step("mw_f1",      0, `BL,  0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        for (int i = 0; i < 4; i++)
            step("mw_hold", 0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 1, 0, 5'b00101);
        step("mw_f2",      0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 1, 1, 5'b11100);
        step("mw_done",    0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // reset mid-flush discards the pending flush
        step("br_f1",      0, `BR,  0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("rst_mid",    1, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b00110);
        step("rst_mid_rel",0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b00110);
        step("rst_mid_run",0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        // memory wait outranks load-use in RUN
        step("mw_over_lu", 0, 4'd0, 0, 4'd3, 4'd2, 1, 4'd3, 1, 0, 5'b00001);
        step("mw_rdy",     0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 1, 1, 5'b11000);

        // back-to-back load-use through rt
        step("lu_rt1",     0, 4'd0, 0, 4'd1, 4'd5, 1, 4'd5, 0, 0, 5'b00010);
        step("lu_rt2",     0, 4'd0, 0, 4'd1, 4'd5, 1, 4'd5, 0, 0, 5'b00010);
        step("lu_end",     0, 4'd0, 0, 4'd1, 4'd5, 0, 4'd5, 0, 0, 5'b11000);
        step("b2_f1",      0, `B,   0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("b2_f2",      0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11100);
        step("b2_done",    0, 4'd0, 0, 4'd1, 4'd2, 0, 4'd0, 0, 0, 5'b11000);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef HAZARD_STATS_EN
        // since the mid-flush reset: 1 memory wait + 2 load-use stalls, 1 branch
        chk("stall_cnt", 32'(stall_count), 32'd3);
        chk("flush_cnt", 32'(flush_count), 32'd1);
        @(posedge clk);
        #1;
        EX_mem_read = 1'b1; EX_rt_rd = 4'd1; ID_rs = 4'd1;
        repeat (32'h10000) @(posedge clk);
        @(negedge clk);
        chk("stall_sat", 32'(stall_count), 32'hFFFF);
        rst = 1'b1;
        #1;
        chk("stall_rst", 32'(stall_count), 32'd0);
        chk("flush_rst", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; EX_mem_read = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
